// File: rtl/aud_pkg.sv
// aud_pkg: types and frame layout shared by the audio memory fetcher and the DAC serializer.
package aud_pkg;
    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int FRAME_BYTES = 4;
    localparam logic [1:0] BYTE_L_LO = 2'd0;
    localparam logic [1:0] BYTE_L_HI = 2'd1;
    localparam logic [1:0] BYTE_R_LO = 2'd2;
    localparam logic [1:0] BYTE_R_HI = 2'd3;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_PUSH} fetch_state_e;
endpackage

// File: rtl/aud_frame_fifo.sv
// aud_frame_fifo: synchronous FIFO of stereo frames; a push at full is accepted only alongside a pop.
module aud_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   iCLK_18_4,
    input  logic                   iRST,
    input  logic                   iFLUSH,
    input  logic                   iPUSH,
    input  logic                   iPOP,
    input  logic [WIDTH-1:0]       iDATA,
    output logic [WIDTH-1:0]       oHEAD,
    output logic                   oFULL,
    output logic                   oEMPTY,
    output logic [$clog2(DEPTH):0] oCOUNT
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_en, rd_en;
    assign oEMPTY = oCOUNT == '0;
    assign oFULL = oCOUNT == (AW+1)'(DEPTH);
    assign wr_en = iPUSH & (~oFULL | iPOP);
    assign rd_en = iPOP & ~oEMPTY;
    assign oHEAD = mem[rd_ptr];
    always_ff @(posedge iCLK_18_4) begin
        if (iRST || iFLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            oCOUNT <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            oCOUNT <= oCOUNT + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    always_ff @(posedge iCLK_18_4) begin
        if (wr_en) mem[wr_ptr] <= iDATA;
    end
endmodule

// File: rtl/aud_mem_fetch.sv
// aud_mem_fetch: streams stereo frames byte-by-byte from sample memory into a frame FIFO
// that the DAC serializer drains once per LRCK frame.
module aud_mem_fetch
    import aud_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST,
    input  logic                  iSTART,
    input  logic                  iSTOP,
    input  logic [ADDR_WIDTH-1:0] iBASE_ADDR,
    input  logic [ADDR_WIDTH-3:0] iFRAME_NUM,
    output logic [ADDR_WIDTH-1:0] oMEM_ADDR,
    output logic                  oMEM_RD,
    input  logic [7:0]            iMEM_DATA,
    input  logic                  iMEM_VALID,
    input  logic                  iSAMPLE_REQ,
    output logic [DATA_WIDTH-1:0] oSAMPLE_L,
    output logic [DATA_WIDTH-1:0] oSAMPLE_R,
    output logic                  oUNDERRUN,
    output logic                  oBUSY
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_e state, state_n;
    logic [ADDR_WIDTH-1:0] ptr, base;
    logic [ADDR_WIDTH-3:0] cnt, last;
    logic [FRAME_BYTES-1:0][7:0] asm_q;
    logic held, flush, push, pop, full, empty, fill_to_full;
    logic [CW-1:0] count;
    logic [2*DATA_WIDTH-1:0] head;
    assign flush = iSTART | iSTOP;
    assign pop = iSAMPLE_REQ & ~empty & ~flush;
    assign push = (state == ST_PUSH) & ~held & ~full & ~flush;
    assign fill_to_full = (count == CW'(FIFO_DEPTH - 1)) & ~pop;
    assign oMEM_ADDR = ptr;
    assign oMEM_RD = state == ST_ISSUE;
    assign oBUSY = state != ST_IDLE;

    aud_frame_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*DATA_WIDTH)) u_fifo (
        .iCLK_18_4(iCLK_18_4),
        .iRST(iRST),
        .iFLUSH(flush),
        .iPUSH(push),
        .iPOP(pop),
        .iDATA({DATA_WIDTH'({asm_q[BYTE_L_HI], asm_q[BYTE_L_LO]}), DATA_WIDTH'({asm_q[BYTE_R_HI], asm_q[BYTE_R_LO]})}),
        .oHEAD(head),
        .oFULL(full),
        .oEMPTY(empty),
        .oCOUNT(count)
    );

    // held marks a frame already written while parked in PUSH waiting for FIFO space
    always_comb begin
        state_n = state;
        if (iSTOP) state_n = ST_IDLE;
        else if (iSTART) state_n = ST_ISSUE;
        else if (state == ST_ISSUE) state_n = ST_WAIT;
        else if (state == ST_WAIT && iMEM_VALID) state_n = (ptr[1:0] == BYTE_R_HI) ? ST_PUSH : ST_ISSUE;
        else if (state == ST_PUSH && (held ? ~full : push & ~fill_to_full)) state_n = ST_ISSUE;
    end

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            state <= ST_IDLE;
            ptr <= '0;
            base <= '0;
            cnt <= '0;
            last <= '0;
            asm_q <= '0;
            held <= 1'b0;
            oSAMPLE_L <= '0;
            oSAMPLE_R <= '0;
            oUNDERRUN <= 1'b0;
        end else begin
            state <= state_n;
            held <= (state_n == ST_PUSH) & (held | push);
            if (iSTART && !iSTOP) begin
                ptr <= iBASE_ADDR;
                base <= iBASE_ADDR;
                cnt <= '0;
                last <= (iFRAME_NUM == '0) ? '0 : iFRAME_NUM - (ADDR_WIDTH-2)'(1);
            end else if (state == ST_WAIT && iMEM_VALID && !iSTOP) begin
                asm_q[ptr[1:0]] <= iMEM_DATA;
                ptr <= ptr + ADDR_WIDTH'(1);
            end else if (push) begin
                ptr <= (cnt == last) ? base : ptr;
                cnt <= (cnt == last) ? '0 : cnt + (ADDR_WIDTH-2)'(1);
            end
            if (pop) {oSAMPLE_L, oSAMPLE_R} <= head;
            oUNDERRUN <= (iSTART && !iSTOP) ? 1'b0 : oUNDERRUN | (iSAMPLE_REQ & empty & ~flush);
        end
    end
endmodule
